// File: rtl/sched_pkg.sv
// Shared types for the quantum scheduler and its round-robin picker.
//   NUM_PROCS_DEFAULT : default number of process slots
//   pid_t             : process-id type at the default slot count
//   sched_state_e     : scheduler FSM states
package sched_pkg;

  localparam int unsigned NUM_PROCS_DEFAULT = 4;

  typedef logic [$clog2(NUM_PROCS_DEFAULT)-1:0] pid_t;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StSave,
    StSelect,
    StDispatch
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority finder.
//   ready : request/ready vector, one bit per slot
//   start : slot with highest priority; priority decreases with wrap-around
//   found : at least one ready bit set
//   pid   : first ready slot at or after start
module rr_pick
  import sched_pkg::*;
#(
  parameter int unsigned N = NUM_PROCS_DEFAULT,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] ready,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] pid
);

  logic [W-1:0] idx;

  // Walk from the farthest offset down to start so the nearest ready slot wins.
  // N is a power of two, so the W-bit add wraps modulo N for free.
  always_comb begin
    found = 1'b0;
    pid   = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = start + W'(i);
      if (ready[idx]) begin
        found = 1'b1;
        pid   = idx;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Round-robin process scheduler driven by the quantum timer interrupt.
//   clock, reset  : system clock, synchronous active-high reset
//   timer_tick    : quantum expiry pulse (honoured only in RUN)
//   cur_pc        : PC of the running process, captured in SAVE
//   create_*      : mark a slot ready with a start PC
//   kill_*        : mark a slot not ready (wins over a same-pid create)
//   stall         : freeze fetch while switching or idle
//   load_pc       : one-cycle strobe, fetch loads next_pc
//   next_pc       : PC to load
//   cur_pid       : running process id
//   timer_reset   : one-cycle timer restart pulse
//   timer_stop    : holds the timer off while idle
//   idle          : no process running
module quantum_scheduler
  import sched_pkg::*;
#(
  parameter  int unsigned NUM_PROCS = NUM_PROCS_DEFAULT,
  parameter  int unsigned PC_W      = 32,
  localparam int unsigned PID_W     = $clog2(NUM_PROCS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             timer_tick,
  input  logic [PC_W-1:0]  cur_pc,
  input  logic             create_valid,
  input  logic [PID_W-1:0] create_pid,
  input  logic [PC_W-1:0]  create_pc,
  input  logic             kill_valid,
  input  logic [PID_W-1:0] kill_pid,
  output logic             stall,
  output logic             load_pc,
  output logic [PC_W-1:0]  next_pc,
  output logic [PID_W-1:0] cur_pid,
  output logic             timer_reset,
  output logic             timer_stop,
  output logic             idle
);

  sched_state_e state_q, state_d;

  logic [NUM_PROCS-1:0] ready_q, ready_d;
  logic [PC_W-1:0]      pc_table_q [NUM_PROCS];
  logic [PID_W-1:0]     cur_pid_q, sel_pid_q;
  logic                 from_idle_q, from_idle_d;

  logic            stall_q, stall_d;
  logic            load_pc_q, load_pc_d;
  logic [PC_W-1:0] next_pc_q, next_pc_d;
  logic            timer_reset_q, timer_reset_d;
  logic            timer_stop_q, timer_stop_d;
  logic            idle_q, idle_d;

  logic             create_ok, kill_cur;
  logic [PID_W-1:0] pick_start, pick_pid;
  logic             pick_found;

  // A create is dropped if the slot is already ready or killed in the same cycle.
  assign create_ok = create_valid && !ready_q[create_pid] &&
                     !(kill_valid && (kill_pid == create_pid));
  assign kill_cur  = kill_valid && (kill_pid == cur_pid_q);

  always_comb begin
    ready_d = ready_q;
    if (create_ok)  ready_d[create_pid] = 1'b1;
    if (kill_valid) ready_d[kill_pid]   = 1'b0;
  end

  // Leaving IDLE searches from slot 0; otherwise cur_pid is considered last.
  assign pick_start = from_idle_q ? '0 : cur_pid_q + 1'b1;

  rr_pick #(
    .N (NUM_PROCS),
    .W (PID_W)
  ) u_rr_pick (
    .ready (ready_q),
    .start (pick_start),
    .found (pick_found),
    .pid   (pick_pid)
  );

  // State register, including the registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      ready_q       <= '0;
      cur_pid_q     <= '0;
      sel_pid_q     <= '0;
      from_idle_q   <= 1'b0;
      stall_q       <= 1'b0;
      load_pc_q     <= 1'b0;
      next_pc_q     <= '0;
      timer_reset_q <= 1'b0;
      timer_stop_q  <= 1'b1;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      from_idle_q   <= from_idle_d;
      if (state_q == StSelect)   sel_pid_q <= pick_pid;
      if (state_q == StDispatch) cur_pid_q <= sel_pid_q;
      stall_q       <= stall_d;
      load_pc_q     <= load_pc_d;
      next_pc_q     <= next_pc_d;
      timer_reset_q <= timer_reset_d;
      timer_stop_q  <= timer_stop_d;
      idle_q        <= idle_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROCS; i++) pc_table_q[i] <= '0;
    end else begin
      if (state_q == StSave) pc_table_q[cur_pid_q] <= cur_pc;
      if (create_ok)         pc_table_q[create_pid] <= create_pc;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    from_idle_d = (state_q == StIdle);
    unique case (state_q)
      StIdle: begin
        if (|ready_q) state_d = StSelect;
      end
      StRun: begin
        // A slot killed during DISPATCH is no longer ready here; treat it as a kill.
        if (kill_cur || !ready_q[cur_pid_q]) state_d = StSelect;
        else if (timer_tick)                 state_d = StSave;
      end
      StSave:     state_d = StSelect;
      StSelect:   state_d = pick_found ? StDispatch : StIdle;
      StDispatch: state_d = StRun;
      default:    state_d = StIdle;
    endcase
  end

  // Output logic, computed for the state being entered so outputs align with it.
  always_comb begin
    stall_d       = 1'b1;
    load_pc_d     = 1'b0;
    next_pc_d     = next_pc_q;
    timer_reset_d = 1'b0;
    timer_stop_d  = 1'b0;
    idle_d        = 1'b0;
    unique case (state_d)
      StIdle: begin
        timer_stop_d = 1'b1;
        idle_d       = 1'b1;
      end
      StRun: stall_d = 1'b0;
      StDispatch: begin
        load_pc_d     = 1'b1;
        timer_reset_d = 1'b1;
        next_pc_d     = pc_table_q[pick_pid];
      end
      default: ;
    endcase
  end

  assign stall       = stall_q;
  assign load_pc     = load_pc_q;
  assign next_pc     = next_pc_q;
  assign cur_pid     = cur_pid_q;
  assign timer_reset = timer_reset_q;
  assign timer_stop  = timer_stop_q;
  assign idle        = idle_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed bench for quantum_scheduler (4 slots, 32-bit PC).
module tb_quantum_scheduler;
  import sched_pkg::*;

  logic        clock, reset;
  logic        timer_tick;
  logic [31:0] cur_pc;
  logic        create_valid;
  pid_t        create_pid;
  logic [31:0] create_pc;
  logic        kill_valid;
  pid_t        kill_pid;
  logic        stall, load_pc, timer_reset, timer_stop, idle;
  logic [31:0] next_pc;
  pid_t        cur_pid;

  int checks;
  int failures;

  quantum_scheduler #(
    .NUM_PROCS (4),
    .PC_W      (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .timer_tick   (timer_tick),
    .cur_pc       (cur_pc),
    .create_valid (create_valid),
    .create_pid   (create_pid),
    .create_pc    (create_pc),
    .kill_valid   (kill_valid),
    .kill_pid     (kill_pid),
    .stall        (stall),
    .load_pc      (load_pc),
    .next_pc      (next_pc),
    .cur_pid      (cur_pid),
    .timer_reset  (timer_reset),
    .timer_stop   (timer_stop),
    .idle         (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_create(input pid_t pid, input logic [31:0] pc);
    create_valid = 1'b1;
    create_pid   = pid;
    create_pc    = pc;
    step();
    create_valid = 1'b0;
  endtask

  // Tick in RUN; returns with the DUT in DISPATCH (three edges later).
  task automatic switch_tick(input logic [31:0] pc);
    timer_tick = 1'b1;
    cur_pc     = pc;
    step();
    timer_tick = 1'b0;
    chk("sw_save_stall", stall, 1);
    chk("sw_save_noload", load_pc, 0);
    step();
    chk("sw_select_noload", load_pc, 0);
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    timer_tick = 1'b0;
    cur_pc = '0;
    create_valid = 1'b0;
    create_pid = '0;
    create_pc = '0;
    kill_valid = 1'b0;
    kill_pid = '0;

    step();
    step();
    chk("rst_stall", stall, 0);
    chk("rst_load_pc", load_pc, 0);
    chk("rst_next_pc", next_pc, 0);
    chk("rst_timer_reset", timer_reset, 0);
    chk("rst_timer_stop", timer_stop, 1);
    chk("rst_idle", idle, 1);
    chk("rst_cur_pid", cur_pid, 0);

    reset = 1'b0;
    step();
    chk("idle_stall", stall, 1);
    chk("idle_idle", idle, 1);

    // First create from IDLE: dispatch three edges after the request.
    do_create(2'd0, 32'h100);
    chk("c0_e1_noload", load_pc, 0);
    step();
    chk("c0_e2_noload", load_pc, 0);
    step();
    chk("c0_load", load_pc, 1);
    chk("c0_next_pc", next_pc, 32'h100);
    chk("c0_timer_reset", timer_reset, 1);
    step();
    chk("c0_idle", idle, 0);
    chk("c0_timer_stop", timer_stop, 0);
    chk("c0_stall", stall, 0);
    chk("c0_load_drop", load_pc, 0);
    chk("c0_cur_pid", cur_pid, 0);

    do_create(2'd1, 32'h200);
    do_create(2'd2, 32'h300);

    // Round robin 0 -> 1 -> 2 -> 0 with PC save/restore.
    switch_tick(32'h140);
    chk("t1_load", load_pc, 1);
    chk("t1_next_pc", next_pc, 32'h200);
    step();
    chk("t1_cur_pid", cur_pid, 1);
    chk("t1_stall", stall, 0);
    switch_tick(32'h240);
    chk("t2_next_pc", next_pc, 32'h300);
    step();
    chk("t2_cur_pid", cur_pid, 2);
    switch_tick(32'h340);
    chk("t3_wrap_next_pc", next_pc, 32'h140);
    step();
    chk("t3_cur_pid", cur_pid, 0);

    // Kill the running pid: straight to SELECT, no SAVE.
    kill_valid = 1'b1;
    kill_pid   = 2'd0;
    step();
    kill_valid = 1'b0;
    chk("k0_stall", stall, 1);
    chk("k0_noload", load_pc, 0);
    step();
    chk("k0_load", load_pc, 1);
    chk("k0_next_pc", next_pc, 32'h240);
    step();
    chk("k0_cur_pid", cur_pid, 1);

    // Kill and tick together: kill wins, same latency as a plain kill.
    kill_valid = 1'b1;
    kill_pid   = 2'd1;
    timer_tick = 1'b1;
    cur_pc     = 32'hbad0;
    step();
    kill_valid = 1'b0;
    timer_tick = 1'b0;
    chk("kt_noload", load_pc, 0);
    step();
    chk("kt_load", load_pc, 1);
    chk("kt_next_pc", next_pc, 32'h340);
    step();
    chk("kt_cur_pid", cur_pid, 2);

    // Create 3 and kill the running 2 in one cycle: both apply.
    create_valid = 1'b1;
    create_pid   = 2'd3;
    create_pc    = 32'h3000;
    kill_valid   = 1'b1;
    kill_pid     = 2'd2;
    step();
    create_valid = 1'b0;
    kill_valid   = 1'b0;
    step();
    chk("ck_load", load_pc, 1);
    chk("ck_next_pc", next_pc, 32'h3000);
    step();
    chk("ck_cur_pid", cur_pid, 3);

    // Sole ready process is re-selected with its saved PC.
    switch_tick(32'h3a0);
    chk("so_load", load_pc, 1);
    chk("so_next_pc", next_pc, 32'h3a0);
    chk("so_timer_reset", timer_reset, 1);
    step();
    chk("so_cur_pid", cur_pid, 3);
    chk("so_timer_reset_drop", timer_reset, 0);

    // Duplicate create on a ready slot is ignored.
    do_create(2'd2, 32'h500);
    do_create(2'd2, 32'hdead);
    switch_tick(32'h3c0);
    chk("dup_next_pc", next_pc, 32'h500);
    step();
    chk("dup_cur_pid", cur_pid, 2);

    // Same-pid create and kill: slot 1 must stay not ready.
    create_valid = 1'b1;
    create_pid   = 2'd1;
    create_pc    = 32'h111;
    kill_valid   = 1'b1;
    kill_pid     = 2'd1;
    step();
    create_valid = 1'b0;
    kill_pid     = 2'd3;
    step();
    kill_valid   = 1'b0;
    chk("ckk_still_run", stall, 0);
    switch_tick(32'h5c0);
    chk("ckk_next_pc", next_pc, 32'h5c0);
    step();
    chk("ckk_cur_pid", cur_pid, 2);

    // Kill the last ready pid: back to IDLE.
    kill_valid = 1'b1;
    kill_pid   = 2'd2;
    step();
    kill_valid = 1'b0;
    chk("kl_select_stall", stall, 1);
    chk("kl_select_idle", idle, 0);
    step();
    chk("kl_idle", idle, 1);
    chk("kl_timer_stop", timer_stop, 1);
    chk("kl_stall", stall, 1);
    step();
    chk("kl_noload", load_pc, 0);

    do_create(2'd2, 32'h300);
    step();
    step();
    chk("rc_load", load_pc, 1);
    chk("rc_next_pc", next_pc, 32'h300);
    step();
    chk("rc_cur_pid", cur_pid, 2);

    // Reset asserted during SAVE.
    timer_tick = 1'b1;
    cur_pc     = 32'h777;
    step();
    timer_tick = 1'b0;
    chk("rs_in_save", stall, 1);
    reset = 1'b1;
    step();
    chk("rs_stall", stall, 0);
    chk("rs_load_pc", load_pc, 0);
    chk("rs_next_pc", next_pc, 0);
    chk("rs_timer_reset", timer_reset, 0);
    chk("rs_timer_stop", timer_stop, 1);
    chk("rs_idle", idle, 1);
    chk("rs_cur_pid", cur_pid, 0);
    reset = 1'b0;
    step();
    step();
    step();
    step();
    chk("rs_after_noload", load_pc, 0);
    chk("rs_after_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
